// File: rtl/param_loader.sv
// param_loader: write-side sequencer for the accelerator RAMs.
// A command (region, base, word count) is followed by a stream of 32-bit words.
// Image and dense words are split byte-wise across four banks in one cycle.
// Conv words are serialized into the single-byte conv RAM, low byte first.
module param_loader #(
  parameter int IMG_DEPTH   = 1024,
  parameter int CONV_DEPTH  = 32768,
  parameter int DENSE_DEPTH = 32768,
  localparam int IMG_AW     = $clog2(IMG_DEPTH),
  localparam int CONV_AW    = $clog2(CONV_DEPTH),
  localparam int DENSE_AW   = $clog2(DENSE_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_region,
  input  logic [14:0]         cmd_base,
  input  logic [14:0]         cmd_len,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [31:0]         wd_data,
  output logic [IMG_AW-1:0]   image_ram_addr_a,
  output logic [7:0]          data_image0,
  output logic [7:0]          data_image1,
  output logic [7:0]          data_image2,
  output logic [7:0]          data_image3,
  output logic                we_image0,
  output logic                we_image1,
  output logic                we_image2,
  output logic                we_image3,
  output logic [CONV_AW-1:0]  conv_ram_addr_a,
  output logic [7:0]          data_conv,
  output logic                we_conv,
  output logic [DENSE_AW-1:0] dense_ram_addr_a,
  output logic [7:0]          data_dense0,
  output logic [7:0]          data_dense1,
  output logic [7:0]          data_dense2,
  output logic [7:0]          data_dense3,
  output logic                we_dense0,
  output logic                we_dense1,
  output logic                we_dense2,
  output logic                we_dense3,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [1:0] REG_IMAGE = 2'd0;
  localparam logic [1:0] REG_CONV  = 2'd1;
  localparam logic [1:0] REG_DENSE = 2'd2;

  typedef enum logic [1:0] {IDLE, WIDE, CONV, FIN} state_t;

  state_t      state;
  logic        dense_sel;
  logic [14:0] base_r;
  logic [14:0] len_r;
  logic [14:0] k_r;
  logic [23:0] word_r;
  logic [1:0]  b_r;
  logic        full_r;
  logic        last_r;
  logic        we_img;
  logic        we_dns;
  logic        cmd_bad;
  logic        last_word;
  logic [17:0] span_wide;
  logic [17:0] span_conv;
  logic [14:0] wide_addr;
  logic [14:0] conv_start;

  // End-of-load addresses are formed with headroom so a huge length can never
  // wrap around and slip past the bounds check.
  assign span_wide  = {3'b000, cmd_base} + {3'b000, cmd_len};
  assign span_conv  = {3'b000, cmd_base} + {1'b0, cmd_len, 2'b00};
  assign wide_addr  = base_r + k_r;
  assign conv_start = base_r + {k_r[12:0], 2'b00};
  assign last_word  = (k_r == len_r - 15'd1);

  // Handshake readies come from registered state only; in CONV a new word is
  // taken while byte 3 of the previous one is on the bus, so strobes stay dense.
  assign cmd_ready = (state == IDLE);
  assign wd_ready  = (state == WIDE) ||
                     ((state == CONV) && (!full_r || (b_r == 2'd3)));

  assign we_image0 = we_img;
  assign we_image1 = we_img;
  assign we_image2 = we_img;
  assign we_image3 = we_img;
  assign we_dense0 = we_dns;
  assign we_dense1 = we_dns;
  assign we_dense2 = we_dns;
  assign we_dense3 = we_dns;

  // Reject reserved regions and any load that would run past the end of its RAM.
  always_comb begin
    cmd_bad = 1'b0;
    case (cmd_region)
      REG_IMAGE: cmd_bad = (span_wide > 18'(IMG_DEPTH)) ||
                           ((cmd_base >> IMG_AW) != 15'd0);
      REG_CONV:  cmd_bad = (span_conv > 18'(CONV_DEPTH));
      REG_DENSE: cmd_bad = (span_wide > 18'(DENSE_DEPTH));
      default:   cmd_bad = 1'b1;
    endcase
  end

  // Sequencer: command decode, wide writes, conv serializer and completion.
  // FIN is the cycle in which the last strobe is visible; done follows it. For
  // an empty load done is raised on entry to FIN instead, so FIN toggles it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      dense_sel        <= 1'b0;
      base_r           <= '0;
      len_r            <= '0;
      k_r              <= '0;
      word_r           <= '0;
      b_r              <= '0;
      full_r           <= 1'b0;
      last_r           <= 1'b0;
      we_img           <= 1'b0;
      we_dns           <= 1'b0;
      we_conv          <= 1'b0;
      image_ram_addr_a <= '0;
      conv_ram_addr_a  <= '0;
      dense_ram_addr_a <= '0;
      data_image0      <= '0;
      data_image1      <= '0;
      data_image2      <= '0;
      data_image3      <= '0;
      data_conv        <= '0;
      data_dense0      <= '0;
      data_dense1      <= '0;
      data_dense2      <= '0;
      data_dense3      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      we_img  <= 1'b0;
      we_dns  <= 1'b0;
      we_conv <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else if (cmd_len == 15'd0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              dense_sel <= (cmd_region == REG_DENSE);
              base_r    <= cmd_base;
              len_r     <= cmd_len;
              k_r       <= '0;
              full_r    <= 1'b0;
              last_r    <= 1'b0;
              busy      <= 1'b1;
              state     <= (cmd_region == REG_CONV) ? CONV : WIDE;
            end
          end
        end
        WIDE: begin
          if (wd_valid) begin
            if (dense_sel) begin
              dense_ram_addr_a <= wide_addr[DENSE_AW-1:0];
              data_dense0      <= wd_data[7:0];
              data_dense1      <= wd_data[15:8];
              data_dense2      <= wd_data[23:16];
              data_dense3      <= wd_data[31:24];
              we_dns           <= 1'b1;
            end else begin
              image_ram_addr_a <= wide_addr[IMG_AW-1:0];
              data_image0      <= wd_data[7:0];
              data_image1      <= wd_data[15:8];
              data_image2      <= wd_data[23:16];
              data_image3      <= wd_data[31:24];
              we_img           <= 1'b1;
            end
            k_r <= k_r + 15'd1;
            if (last_word) state <= FIN;
          end
        end
        CONV: begin
          if (!full_r || (b_r == 2'd3)) begin
            if (wd_valid) begin
              conv_ram_addr_a <= conv_start[CONV_AW-1:0];
              data_conv       <= wd_data[7:0];
              we_conv         <= 1'b1;
              word_r          <= wd_data[31:8];
              b_r             <= 2'd0;
              full_r          <= 1'b1;
              last_r          <= last_word;
              k_r             <= k_r + 15'd1;
            end else begin
              full_r <= 1'b0;
            end
          end else begin
            conv_ram_addr_a <= conv_ram_addr_a + CONV_AW'(1);
            data_conv       <= word_r[7:0];
            we_conv         <= 1'b1;
            word_r          <= {8'd0, word_r[23:8]};
            b_r             <= b_r + 2'd1;
            if ((b_r == 2'd2) && last_r) state <= FIN;
          end
        end
        FIN: begin
          done  <= !done;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
